qos_wrr_sched: RTL

//  Weighted round-robin scheduler for the QoS PCIE path, between the 4 per-class ingress FIFOs and the 4 per-class egress FIFOs.
//  - Picks at most one class per cycle. Pops that class's ingress FIFO, and 1 cycle later pushes the word into the matching egress FIFO.
//  - Honours egress almost_full backpressure.
//  - Replaces a fixed-priority arbiter with per-class programmable weights, loaded while in INIT.

---
 rtl/qos_wrr_sched_pkg.sv | 31 +++
 rtl/qos_wrr_sched_rr_pick.sv | 16 +
 rtl/qos_wrr_sched.sv | 139 +++++++++++++
 3 files changed

// File: rtl/qos_wrr_sched_pkg.sv
// Shared types and helpers for the QoS weighted round-robin scheduler.
package qos_wrr_sched_pkg;

    localparam int unsigned NCLS = 4;
    localparam int unsigned IDXW = 2;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // First set bit of mask searching cur+1, cur+2, cur+3, cur (mod NCLS).
    function automatic logic [IDXW-1:0] next_elig(input logic [IDXW-1:0] cur,
                                                  input logic [NCLS-1:0] mask);
        logic [IDXW-1:0] c;
        logic [IDXW-1:0] r;
        logic            found;
        r     = cur;
        found = 1'b0;
        for (int unsigned k = 1; k <= NCLS; k++) begin
            c = cur + IDXW'(k);
            if (!found && mask[c]) begin
                r     = c;
                found = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/qos_wrr_sched_rr_pick.sv
// Combinational 4-way cyclic priority pick: start index + request mask -> one-hot and index.
module qos_wrr_sched_rr_pick
    import qos_wrr_sched_pkg::*;
(
    input  logic [IDXW-1:0] start,
    input  logic [NCLS-1:0] req,
    output logic [NCLS-1:0] gnt_c,
    output logic [IDXW-1:0] idx_c,
    output logic            valid_c
);

    assign valid_c = |req;
    assign idx_c   = next_elig(start, req);
    assign gnt_c   = valid_c ? (NCLS'(1) << idx_c) : '0;

endmodule

// File: rtl/qos_wrr_sched.sv
// Weighted round-robin scheduler between 4 per-class ingress and egress FIFOs.
// Optional QOS_STRICT_P0_EN: class 0 becomes strict priority, WRR covers classes 1..3.
module qos_wrr_sched
    import qos_wrr_sched_pkg::*;
#(
    parameter int unsigned DW = 12,
    parameter int unsigned WW = 4
) (
    input  logic            clk,
    input  logic            reset_L,
    input  logic            enable,
    input  logic            cfg_load,
    input  logic [WW-1:0]   cfg_weight0,
    input  logic [WW-1:0]   cfg_weight1,
    input  logic [WW-1:0]   cfg_weight2,
    input  logic [WW-1:0]   cfg_weight3,
    input  logic [NCLS-1:0] in_empty,
    input  logic [NCLS-1:0] out_afull,
    input  logic [DW-1:0]   in_data0,
    input  logic [DW-1:0]   in_data1,
    input  logic [DW-1:0]   in_data2,
    input  logic [DW-1:0]   in_data3,
    output logic [NCLS-1:0] pop,
    output logic [NCLS-1:0] push,
    output logic [DW-1:0]   data_out,
    output logic            busy,
    output logic [1:0]      state
);

    state_e                   state_q, state_d;
    logic [IDXW-1:0]          cur_q, cur_d;
    logic [WW-1:0]            credit_q, credit_d;
    logic [NCLS-1:0][WW-1:0]  weight_q, weight_d, cfg_w;
    logic [NCLS-1:0]          push_q, push_d;
    logic [DW-1:0]            data_q, data_d;
    logic [NCLS-1:0][DW-1:0]  in_data;
    logic [NCLS-1:0]          elig, wrr_mask, grant;
    logic [IDXW-1:0]          grant_idx;
    logic [NCLS-1:0]          wrr_gnt;
    logic [IDXW-1:0]          wrr_idx;
    logic                     wrr_valid;

    assign cfg_w   = {cfg_weight3, cfg_weight2, cfg_weight1, cfg_weight0};
    assign in_data = {in_data3, in_data2, in_data1, in_data0};
    assign elig    = ~in_empty & ~out_afull;

`ifdef QOS_STRICT_P0_EN
    logic [NCLS-1:0] p0_gnt;
    logic [IDXW-1:0] p0_idx;
    logic            p0_valid;

    assign wrr_mask = elig & 4'b1110;

    // Start at 3 so class 0 is searched first; only class 0 may request.
    qos_wrr_sched_rr_pick u_p0_pick (
        .start   (IDXW'(3)),
        .req     ({3'b000, elig[0]}),
        .gnt_c   (p0_gnt),
        .idx_c   (p0_idx),
        .valid_c (p0_valid)
    );
`else
    assign wrr_mask = elig;
`endif

    qos_wrr_sched_rr_pick u_wrr_pick (
        .start   (cur_q),
        .req     (wrr_mask),
        .gnt_c   (wrr_gnt),
        .idx_c   (wrr_idx),
        .valid_c (wrr_valid)
    );

    // Next-state, arbitration and datapath capture.
    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        credit_d  = credit_q;
        weight_d  = weight_q;
        grant     = '0;
        grant_idx = cur_q;
        case (state_q)
            ST_INIT: begin
                if (enable)        state_d  = ST_RUN;
                else if (cfg_load) weight_d = cfg_w;
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_HOLD;
                end else
`ifdef QOS_STRICT_P0_EN
                if (p0_valid) begin
                    grant     = p0_gnt;
                    grant_idx = p0_idx;
                end else
`endif
                if (wrr_mask[cur_q] && (credit_q != '0)) begin
                    grant    = NCLS'(1) << cur_q;
                    credit_d = credit_q - WW'(1);
                end else if (wrr_valid) begin
                    grant     = wrr_gnt;
                    grant_idx = wrr_idx;
                    cur_d     = wrr_idx;
                    // Weight 0 behaves as 1, leaving no extra credit.
                    credit_d  = (weight_q[wrr_idx] == '0) ? '0 : weight_q[wrr_idx] - WW'(1);
                end
            end
            ST_HOLD: state_d = ST_INIT;
            default: state_d = ST_INIT;
        endcase
        push_d = grant;
        data_d = (|grant) ? in_data[grant_idx] : data_q;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q  <= ST_INIT;
            cur_q    <= IDXW'(3);
            credit_q <= '0;
            weight_q <= {NCLS{WW'(1)}};
            push_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            credit_q <= credit_d;
            weight_q <= weight_d;
            push_q   <= push_d;
            data_q   <= data_d;
        end
    end

    assign pop      = grant;
    assign push     = push_q;
    assign data_out = data_q;
    assign busy     = (|grant) | (|push_q);
    assign state    = state_q;

endmodule
